// File: rtl/imm_pkg.sv
// imm_pkg: shared constants for the immediate-extender arbiter.
//   - EXT_* : 2-bit extender operation codes
//   - OPC_* : MIPS-I primary opcodes (instr[31:26]) that carry an immediate
//   - PORT_*: requester indices (decode stage, branch-target precompute)
package imm_pkg;

   localparam logic [1:0] EXT_SIGN = 2'b00;
   localparam logic [1:0] EXT_ZERO = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;
   localparam logic [1:0] EXT_BR   = 2'b11;

   localparam logic [5:0] OPC_REGIMM = 6'b000001;
   localparam logic [5:0] OPC_BEQ    = 6'b000100;
   localparam logic [5:0] OPC_BNE    = 6'b000101;
   localparam logic [5:0] OPC_BLEZ   = 6'b000110;
   localparam logic [5:0] OPC_BGTZ   = 6'b000111;
   localparam logic [5:0] OPC_ADDI   = 6'b001000;
   localparam logic [5:0] OPC_ADDIU  = 6'b001001;
   localparam logic [5:0] OPC_SLTI   = 6'b001010;
   localparam logic [5:0] OPC_SLTIU  = 6'b001011;
   localparam logic [5:0] OPC_ANDI   = 6'b001100;
   localparam logic [5:0] OPC_ORI    = 6'b001101;
   localparam logic [5:0] OPC_XORI   = 6'b001110;
   localparam logic [5:0] OPC_LUI    = 6'b001111;
   localparam logic [5:0] OPC_LB     = 6'b100000;
   localparam logic [5:0] OPC_LH     = 6'b100001;
   localparam logic [5:0] OPC_LW     = 6'b100011;
   localparam logic [5:0] OPC_LBU    = 6'b100100;
   localparam logic [5:0] OPC_LHU    = 6'b100101;
   localparam logic [5:0] OPC_SB     = 6'b101000;
   localparam logic [5:0] OPC_SH     = 6'b101001;
   localparam logic [5:0] OPC_SW     = 6'b101011;

   localparam logic PORT_DEC = 1'b0;
   localparam logic PORT_BR  = 1'b1;

endpackage

// File: rtl/ext.sv
// ext: 16-to-32 bit immediate extender.
//   imm in  16  raw immediate field
//   op  in  2   EXT_SIGN / EXT_ZERO / EXT_LUI / EXT_BR
//   y   out 32  extended immediate
module ext
   import imm_pkg::*;
(
   input  logic [15:0] imm,
   input  logic [1:0]  op,
   output logic [31:0] y
);

   always_comb begin
      y = {{16{imm[15]}}, imm};
      case (op)
         EXT_ZERO: y = {16'h0000, imm};
         EXT_LUI:  y = {imm, 16'h0000};
         EXT_BR:   y = {{14{imm[15]}}, imm, 2'b00};
         default:  y = {{16{imm[15]}}, imm};
      endcase
   end

endmodule

// File: rtl/imm_decode.sv
// imm_decode: combinational opcode classifier.
//   opcode  in  6  instr[31:26]
//   op      out 2  extender operation (EXT_*)
//   illegal out 1  opcode has no immediate form (op reads EXT_SIGN)
module imm_decode
   import imm_pkg::*;
(
   input  logic [5:0] opcode,
   output logic [1:0] op,
   output logic       illegal
);

   always_comb begin
      op      = EXT_SIGN;
      illegal = 1'b0;
      case (opcode)
         OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU,
         OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU,
         OPC_SB, OPC_SH, OPC_SW:                     op = EXT_SIGN;
         OPC_ANDI, OPC_ORI, OPC_XORI:                op = EXT_ZERO;
         OPC_LUI:                                    op = EXT_LUI;
         OPC_BEQ, OPC_BNE, OPC_BLEZ, OPC_BGTZ,
         OPC_REGIMM:                                 op = EXT_BR;
         default:                                    illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_arbiter.sv
// imm_arbiter: shares one immediate extender between two requesters and
// returns the result through a one-entry registered valid/ready channel.
//   clk, reset_n            clock, asynchronous active-low reset
//   ReqValid[1:0]/ReqReady  per-port request handshake (0 = decode, 1 = branch)
//   ReqInstr0/ReqInstr1     raw 32-bit instructions
//   RspValid/RspReady       response handshake
//   RspId, RspData, RspIllegal  granted port, extended immediate, no-immediate flag
// Build option: IMM_ARB_RR_EN selects round-robin tie breaking; without it
// port 0 always wins ties and no pointer register exists.
module imm_arbiter
   import imm_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  ReqValid,
   input  logic [31:0] ReqInstr0,
   input  logic [31:0] ReqInstr1,
   output logic [1:0]  ReqReady,
   output logic        RspValid,
   input  logic        RspReady,
   output logic        RspId,
   output logic [31:0] RspData,
   output logic        RspIllegal
);

   logic [1:0]  grant;
   logic        sel_id;
   logic [31:0] instr_sel;
   logic [1:0]  dec_op;
   logic        dec_illegal;
   logic [31:0] ext_y;
   logic        can_load;
   logic        req_hs;
   logic        rsp_hs;
   logic        unused_instr_bits;

   logic        rsp_valid_q,   rsp_valid_d;
   logic        rsp_id_q,      rsp_id_d;
   logic [31:0] rsp_data_q,    rsp_data_d;
   logic        rsp_illegal_q, rsp_illegal_d;

`ifdef IMM_ARB_RR_EN
   // Index of the port granted on the last request handshake.
   logic ptr_q, ptr_d;

   always_comb begin
      grant = ReqValid;
      if (ReqValid == 2'b11)
         grant = (ptr_q == PORT_BR) ? 2'b01 : 2'b10;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (req_hs)
         ptr_d = sel_id;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ptr_q <= PORT_BR;
      else          ptr_q <= ptr_d;
   end
`else
   always_comb begin
      grant = ReqValid;
      if (ReqValid == 2'b11)
         grant = 2'b01;
   end
`endif

   // grant is one-hot or zero, so bit 1 is the granted port index.
   assign sel_id    = grant[1];
   assign instr_sel = sel_id ? ReqInstr1 : ReqInstr0;
   assign unused_instr_bits = ^instr_sel[25:16];

   imm_decode u_decode (
      .opcode  (instr_sel[31:26]),
      .op      (dec_op),
      .illegal (dec_illegal)
   );

   ext u_ext (
      .imm (instr_sel[15:0]),
      .op  (dec_op),
      .y   (ext_y)
   );

   // The register may load when empty or being drained this cycle.
   assign can_load = !rsp_valid_q || RspReady;
   assign ReqReady = grant & {2{can_load}};
   assign req_hs   = |grant && can_load;
   assign rsp_hs   = rsp_valid_q && RspReady;

   always_comb begin
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_data_d    = rsp_data_q;
      rsp_illegal_d = rsp_illegal_q;
      if (req_hs) begin
         rsp_valid_d   = 1'b1;
         rsp_id_d      = sel_id;
         rsp_data_d    = dec_illegal ? 32'h0 : ext_y;
         rsp_illegal_d = dec_illegal;
      end else if (rsp_hs) begin
         rsp_valid_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= PORT_DEC;
         rsp_data_q    <= 32'h0;
         rsp_illegal_q <= 1'b0;
      end else begin
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_data_q    <= rsp_data_d;
         rsp_illegal_q <= rsp_illegal_d;
      end
   end

   assign RspValid   = rsp_valid_q;
   assign RspId      = rsp_id_q;
   assign RspData    = rsp_data_q;
   assign RspIllegal = rsp_illegal_q;

endmodule

// File: tb/tb_imm_arbiter.sv
// tb_imm_arbiter: scoreboard bench for imm_arbiter. The driver issues one
// request pattern per cycle, predicts grants and results from the opcode
// table, and queues expected responses; a monitor pops and compares them.
module tb_imm_arbiter;

   logic        clk;
   logic        reset_n;
   logic [1:0]  ReqValid;
   logic [31:0] ReqInstr0;
   logic [31:0] ReqInstr1;
   logic [1:0]  ReqReady;
   logic        RspValid;
   logic        RspReady;
   logic        RspId;
   logic [31:0] RspData;
   logic        RspIllegal;

   imm_arbiter dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ReqValid   (ReqValid),
      .ReqInstr0  (ReqInstr0),
      .ReqInstr1  (ReqInstr1),
      .ReqReady   (ReqReady),
      .RspValid   (RspValid),
      .RspReady   (RspReady),
      .RspId      (RspId),
      .RspData    (RspData),
      .RspIllegal (RspIllegal)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Scoreboard entry: {id, illegal, data}
   logic [33:0] sb_q[$];
   logic        pend_exp = 1'b0;
   logic        mon_en   = 1'b0;
   int          last_port = 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference extension straight from the opcode table.
   function automatic void ref_ext(input logic [31:0] ins, output logic [31:0] d, output logic ill);
      logic [5:0]  opc;
      logic [15:0] imm;
      int signed   sv;
      opc = ins[31:26];
      imm = ins[15:0];
      sv  = int'($signed(imm));
      ill = 1'b0;
      if (opc inside {6'd8, 6'd9, 6'd10, 6'd11, 6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43})
         d = sv;
      else if (opc inside {6'd12, 6'd13, 6'd14})
         d = {16'h0, imm};
      else if (opc == 6'd15)
         d = {imm, 16'h0};
      else if (opc inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7})
         d = sv * 4;
      else begin
         d   = 32'h0;
         ill = 1'b1;
      end
   endfunction

   // One cycle of stimulus: drive at the falling edge, predict, push.
   task automatic cycle(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1, input logic rdy);
      int          winner;
      logic [1:0]  exp_rdy;
      logic        pending;
      logic [31:0] d;
      logic        ill;
      @(negedge clk);
      ReqValid  = v;
      ReqInstr0 = i0;
      ReqInstr1 = i1;
      RspReady  = rdy;
      #1;
      pending  = (sb_q.size() > 0);
      pend_exp = pending;
      winner   = -1;
      if (v == 2'b01) winner = 0;
      else if (v == 2'b10) winner = 1;
      else if (v == 2'b11) begin
`ifdef IMM_ARB_RR_EN
         winner = (last_port == 0) ? 1 : 0;
`else
         winner = 0;
`endif
      end
      exp_rdy = 2'b00;
      if (winner >= 0 && (!pending || rdy))
         exp_rdy[winner] = 1'b1;
      check("req_ready", {30'h0, ReqReady}, {30'h0, exp_rdy});
      if (exp_rdy != 2'b00) begin
         ref_ext((winner == 1) ? i1 : i0, d, ill);
         sb_q.push_back({winner[0], ill, d});
         last_port = winner;
      end
   endtask

   // Monitor: response is consumed at the next rising edge when RspReady=1.
   always begin
      logic [33:0] e;
      @(negedge clk);
      #3;
      if (mon_en) begin
         check("rsp_valid", {31'h0, RspValid}, {31'h0, pend_exp});
         if (RspValid) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL rsp_unexpected: got id=%0d data=0x%08h expected no response", RspId, RspData);
            end else begin
               e = sb_q[0];
               check("rsp_id", {31'h0, RspId}, {31'h0, e[33]});
               check("rsp_illegal", {31'h0, RspIllegal}, {31'h0, e[32]});
               check("rsp_data", RspData, e[31:0]);
               if (RspReady) void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   logic [5:0] legal_opc[21] = '{6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13,
                                 6'd14, 6'd15, 6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43};

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [5:0]  opc;
      r = $urandom();
      if ($urandom_range(0, 3) != 0) opc = legal_opc[$urandom_range(0, 20)];
      else                           opc = 6'($urandom_range(0, 63));
      return {opc, r[25:0]};
   endfunction

   initial begin
      reset_n   = 1'b0;
      ReqValid  = 2'b00;
      ReqInstr0 = 32'h0;
      ReqInstr1 = 32'h0;
      RspReady  = 1'b0;
      #5;
      check("reset_rsp_valid", {31'h0, RspValid}, 32'h0);
      check("reset_rsp_id", {31'h0, RspId}, 32'h0);
      check("reset_rsp_data", RspData, 32'h0);
      check("reset_rsp_illegal", {31'h0, RspIllegal}, 32'h0);
      check("reset_req_ready", {30'h0, ReqReady}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // Single-port transactions from the opcode classes
      cycle(2'b01, 32'h34008000, 32'h0, 1'b1);
      cycle(2'b10, 32'h0, 32'h1000FFFE, 1'b1);
      cycle(2'b01, 32'h2000FFFF, 32'h0, 1'b1);
      cycle(2'b01, 32'h3C001234, 32'h0, 1'b1);
      cycle(2'b01, 32'h00000000, 32'h0, 1'b1);
      cycle(2'b00, 32'h0, 32'h0, 1'b1);
      cycle(2'b00, 32'h0, 32'h0, 1'b1);

      // Continuous tie
      for (int k = 0; k < 4; k++)
         cycle(2'b11, 32'h34000000 | k, 32'h04000010 | k, 1'b1);

      // Backpressure then back-to-back drain
      cycle(2'b01, 32'h3400ABCD, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++)
         cycle(2'b11, 32'h24008001, 32'h1C007FFF, 1'b0);
      cycle(2'b11, 32'h24008001, 32'h1C007FFF, 1'b1);
      cycle(2'b10, 32'h0, 32'h8C00FFF0, 1'b1);
      cycle(2'b00, 32'h0, 32'h0, 1'b1);

      // Randomised traffic
      for (int k = 0; k < 400; k++)
         cycle(2'($urandom_range(0, 3)), rand_instr(), rand_instr(), ($urandom_range(0, 9) < 7));

      // Reset while a response is pending
      cycle(2'b00, 32'h0, 32'h0, 1'b1);
      cycle(2'b01, 32'h34005555, 32'h0, 1'b0);
      cycle(2'b00, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      mon_en   = 1'b0;
      ReqValid = 2'b00;
      #1;
      check("pre_reset_pending", {31'h0, RspValid}, 32'h1);
      reset_n = 1'b0;
      #1;
      check("async_reset_valid", {31'h0, RspValid}, 32'h0);
      check("async_reset_data", RspData, 32'h0);
      sb_q.delete();
      last_port = 1;
      pend_exp  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      cycle(2'b11, 32'h34000042, 32'h10000001, 1'b1);
      cycle(2'b11, 32'h34000043, 32'h10000002, 1'b1);
      cycle(2'b00, 32'h0, 32'h0, 1'b1);
      cycle(2'b00, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      #5;
      check("drain_empty", sb_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
